rll_decoder: RTL
================

Name: rll_decoder

Overview:
- Receive-side stage directly downstream of the RLL(2,7) encoder.
- Takes the serial NRZI line level, one code bit per strobe, and recovers the transition stream (1 = transition "R", 0 = none "N").
- Parses the variable-length (2,7) codewords and packs the decoded data bits into OUT_W-bit words.
- With the default OUT_W = 4, output words match the encoder's 4-bit data input.

Parameters:
- OUT_W, 4: width of the decoded output word; legal values are 4..8.
- INIT_LEVEL, 1'b0: line level assumed before the first received bit.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- line_i  input  1  NRZI line level; sampled only when line_valid_i=1.
- line_valid_i  input  1  one code bit present this cycle.
- flush_i  input  1  synchronous clear of partial codeword and packer.
- data_o  output  OUT_W  decoded word; first-decoded bit is the MSB.
- data_valid_o  output  1  one-cycle strobe, data_o valid.
- code_err_o  output  1  one-cycle strobe, illegal codeword discarded.
- rl_err_o  output  1  run-length violation strobe; see Optional Feature.

Behaviour:
- Reset (rst_ni=0, asynchronous): prev_level=INIT_LEVEL; code accumulator and count = 0; packer and count = 0; data_o=0; data_valid_o=0; code_err_o=0; rl_err_o=0. Reset may assert mid-symbol; all partial state is lost.
- Per accepted bit: t = line_i XOR prev_level, then prev_level <= line_i.
- Codeword accumulator: code_q holds up to 8 bits, cnt_q ranges 0..7. Append t, giving new length L = cnt_q+1.
- Codeword match table (code -> data, first bit leftmost):
  - L=4: 1000->11, 0100->10.
  - L=6: 001000->011, 100100->010, 000100->000.
  - L=8: 00001000->0011, 00100100->0010.
- On a match, append the data bits to the packer and clear the accumulator.
- If L=8 with no match: code_err_o=1 for one cycle, accumulator cleared, no data added.
- Packer: holds up to OUT_W+3 bits.
  - When the packer count is >= OUT_W after an append, register the oldest OUT_W bits to data_o, pulse data_valid_o, and shift the remainder down.
  - At most one word is emitted per cycle.
- Latency: data_valid_o, code_err_o and rl_err_o are registered. They assert in the cycle after the clock edge that sampled the completing bit.
- Between words, data_o holds its last value and data_valid_o=0.
- line_valid_i=0: no state changes; all strobes deassert.
- flush_i=1: accumulator and packer cleared, no strobes.
- flush_i=1 together with line_valid_i=1: flush wins and the bit is not decoded, but prev_level <= line_i is still applied.
- Back-to-back line_valid_i on every cycle is supported. There is no backpressure.

Optional Feature:
- Macro: RLL_RUNLEN_CHECK_EN.
- Enabled:
  - Track the zero run between transitions on t with a 4-bit counter.
  - rl_err_o pulses for one cycle if a 1 follows fewer than 2 zeros (d violation), or if a zero run reaches 8 (k violation). The k violation fires once per run.
  - The run counter is cleared by reset and by flush_i.
  - The very first transition after reset or flush is exempt from the d check.
- Disabled: rl_err_o is tied to 0 and no run counter is built.
- Decoding behaviour is identical in both cases.

Test Plan:
- Levels 1,1,1,1,1,0,0,0, INIT_LEVEL=0 (t=1000 0100) -> exactly one data_valid_o, data_o=4'b1110, one cycle after the 8th bit; code_err_o stays 0.
- t=00001000 then t=00100100 -> data_o=4'b0011, then data_o=4'b0010, each strobe one cycle after the 8th bit of its codeword.
- t=001000 100100 0100 (data 011,010,10) -> first word 4'b0110 after bit 12; second word 4'b1010 after bit 16.
- t=11111111 -> code_err_o pulses once after bit 8; no data_valid_o. A following t=1000 0100 still decodes to 4'b1110.
- Flush:
  - Send t=0010, then flush_i=1 for one cycle, then t=1000 0100 -> data_o=4'b1110; the partial 0010 is discarded.
  - Assert rst_ni low mid-codeword -> all outputs 0 immediately.
- RLL_RUNLEN_CHECK_EN:
  - Defined: t=1000, then 1,1 -> rl_err_o pulses on the second adjacent 1.
  - Defined: nine consecutive zeros -> one rl_err_o pulse.
  - Undefined: rl_err_o stays 0 for the same stimulus.

Source files
------------

// File: rtl/rll_decoder.sv
// rll_decoder: NRZI line to RLL(2,7) codeword parser and data-word packer.
// Ports: clk_i/rst_ni clock and async active-low reset; line_i/line_valid_i serial
// line level and its strobe; flush_i drops any partial codeword and packed bits;
// data_o/data_valid_o decoded OUT_W-bit word (first decoded bit in the MSB);
// code_err_o illegal-codeword strobe; rl_err_o run-length violation strobe.
// Define RLL_RUNLEN_CHECK_EN to build the run-length checker behind rl_err_o.
module rll_decoder #(
  parameter int unsigned OUT_W      = 4,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             line_i,
  input  logic             line_valid_i,
  input  logic             flush_i,
  output logic [OUT_W-1:0] data_o,
  output logic             data_valid_o,
  output logic             code_err_o,
  output logic             rl_err_o
);
  localparam int unsigned PW = OUT_W + 3;
  logic             prev_q;
  logic [7:0]       code_q;
  logic [2:0]       cnt_q;
  logic [PW-1:0]    pk_q;
  logic [3:0]       pc_q;
  logic             t;
  logic [7:0]       code_n;
  logic [3:0]       len;
  logic [3:0]       dbits;
  logic [2:0]       dlen;
  logic             hit;
  logic [PW-1:0]    pk_sh;
  logic [3:0]       pc_sh;
  logic [3:0]       extra;
  logic             emit;
  logic [OUT_W-1:0] word;
  logic [PW-1:0]    rem;
  // Codewords shift in at the LSB, so the first received bit sits leftmost.
  always_comb begin
    t      = line_i ^ prev_q;
    code_n = {code_q[6:0], t};
    len    = {1'b0, cnt_q} + 4'd1;
    dbits  = 4'b0000;
    dlen   = 3'd0;
    casez ({len, code_n})
      {4'd4, 8'b????1000}: begin dbits = 4'b0011; dlen = 3'd2; end
      {4'd4, 8'b????0100}: begin dbits = 4'b0010; dlen = 3'd2; end
      {4'd6, 8'b??001000}: begin dbits = 4'b0011; dlen = 3'd3; end
      {4'd6, 8'b??100100}: begin dbits = 4'b0010; dlen = 3'd3; end
      {4'd6, 8'b??000100}: begin dbits = 4'b0000; dlen = 3'd3; end
      {4'd8, 8'b00001000}: begin dbits = 4'b0011; dlen = 3'd4; end
      {4'd8, 8'b00100100}: begin dbits = 4'b0010; dlen = 3'd4; end
      default:             begin dbits = 4'b0000; dlen = 3'd0; end
    endcase
    hit   = dlen != 3'd0;
    // Packer keeps the oldest bits at the top of its valid count.
    pk_sh = (pk_q << dlen) | PW'(dbits);
    pc_sh = pc_q + {1'b0, dlen};
    emit  = pc_sh >= 4'(OUT_W);
    extra = pc_sh - 4'(OUT_W);
    word  = OUT_W'(pk_sh >> extra);
    rem   = pk_sh & ~({PW{1'b1}} << extra);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q       <= INIT_LEVEL;
      code_q       <= '0;
      cnt_q        <= '0;
      pk_q         <= '0;
      pc_q         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      code_err_o   <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      code_err_o   <= 1'b0;
      if (line_valid_i) prev_q <= line_i;
      if (flush_i) begin
        code_q <= '0;
        cnt_q  <= '0;
        pk_q   <= '0;
        pc_q   <= '0;
      end else if (line_valid_i) begin
        code_q     <= (hit || len[3]) ? 8'd0 : code_n;
        cnt_q      <= hit ? 3'd0 : len[2:0];
        code_err_o <= len[3] && !hit;
        if (emit) begin
          data_o       <= word;
          data_valid_o <= 1'b1;
          pk_q         <= rem;
          pc_q         <= extra;
        end else begin
          pk_q <= pk_sh;
          pc_q <= pc_sh;
        end
      end
    end
  end
`ifdef RLL_RUNLEN_CHECK_EN
  logic [3:0] run_q;
  logic       first_q;
  // run_q counts zeros since the last transition; it saturates so a long run
  // reports its k violation only once, when it first reaches 8.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= '0;
      first_q  <= 1'b1;
      rl_err_o <= 1'b0;
    end else begin
      rl_err_o <= 1'b0;
      if (flush_i) begin
        run_q   <= '0;
        first_q <= 1'b1;
      end else if (line_valid_i) begin
        if (t) begin
          rl_err_o <= !first_q && run_q < 4'd2;
          run_q    <= '0;
          first_q  <= 1'b0;
        end else begin
          rl_err_o <= run_q == 4'd7;
          run_q    <= (run_q == 4'd15) ? run_q : run_q + 4'd1;
        end
      end
    end
  end
`else
  assign rl_err_o = 1'b0;
`endif
endmodule
